// File: rtl/sw_dev_if.sv
// Device-side endpoint of a switch port. It bridges host valid/ready streams to the port's 4-phase TX/RX handshakes.
// Optional TX acknowledge timeout: define SW_DEV_IF_TIMEOUT_EN.
module sw_dev_if #(
  parameter int DW     = 4,
  parameter int AW_DEV = 2,
  parameter int TO_CYC = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // host TX stream
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [DW-1:0]      tx_data,
  input  logic [AW_DEV:0]    tx_adr,
  output logic               tx_done,
  output logic               tx_err,
  // port TX handshake (this block initiates)
  output logic               validtx,
  output logic [DW-1:0]      dat_tx,
  output logic [AW_DEV:0]    adr_tx,
  input  logic               acktx,
  // port RX handshake (this block responds)
  input  logic               validrx,
  input  logic [DW+AW_DEV:0] dat_rx,
  output logic               ackrx,
  // host RX stream
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [DW-1:0]      rx_data,
  output logic [AW_DEV:0]    rx_adr
);

  if (TO_CYC < 2) begin : g_bad_to_cyc
    $error("sw_dev_if: TO_CYC must be at least 2");
  end

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_t;
  typedef enum logic       {R_IDLE, R_ACK}        rx_state_t;

  tx_state_t tx_state;
  rx_state_t rx_state;
  logic      ack_min;
  logic      to_hit;

`ifdef SW_DEV_IF_TIMEOUT_EN
  localparam int            CW      = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] to_cnt;

  // acktx in the timeout cycle suppresses the timeout, so the ack always wins.
  assign to_hit = (tx_state == T_REQ) && !acktx && (to_cnt == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt <= '0;
      tx_err <= 1'b0;
    end else begin
      tx_err <= to_hit;
      if (tx_state == T_IDLE)
        to_cnt <= '0;
      else if ((tx_state == T_REQ) && !acktx && !to_hit)
        to_cnt <= to_cnt + CW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
  assign tx_err = 1'b0;
`endif

  // TX initiator: registered outputs, one transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the async reset clears validtx at once, abandoning a handshake in flight.
      tx_state <= T_IDLE;
      tx_ready <= 1'b1;
      validtx  <= 1'b0;
      dat_tx   <= '0;
      adr_tx   <= '0;
      tx_done  <= 1'b0;
    end else begin
      // NOTE: all state uses non-blocking updates, so every branch reads pre-edge values.
      tx_done <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          if (tx_valid && tx_ready) begin
            dat_tx   <= tx_data;
            adr_tx   <= tx_adr;
            // A stale acktx defers the request until the port releases it.
            validtx  <= !acktx;
            tx_ready <= 1'b0;
            tx_state <= T_REQ;
          end
        end
        T_REQ: begin
          if (validtx && acktx) begin
            validtx  <= 1'b0;
            tx_state <= T_REL;
          end else if (to_hit) begin
            validtx  <= 1'b0;
            tx_ready <= 1'b1;
            tx_state <= T_IDLE;
          end else if (!validtx && !acktx) begin
            validtx <= 1'b1;
          end
        end
        T_REL: begin
          if (!acktx) begin
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            tx_state <= T_IDLE;
          end
        end
        default: begin
          validtx  <= 1'b0;
          tx_ready <= 1'b1;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

  // RX responder: one-word buffer. ackrx is held at least two cycles for the port's edge detector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state <= R_IDLE;
      ackrx    <= 1'b0;
      ack_min  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_adr   <= '0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (validrx && (!rx_valid || rx_ready)) begin
            rx_data  <= dat_rx[DW-1:0];
            rx_adr   <= dat_rx[DW+AW_DEV:DW];
            rx_valid <= 1'b1;
            ackrx    <= 1'b1;
            ack_min  <= 1'b0;
            rx_state <= R_ACK;
          end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
          end
        end
        R_ACK: begin
          if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
          if (ack_min && !validrx) begin
            ackrx    <= 1'b0;
            rx_state <= R_IDLE;
          end else begin
            ack_min <= 1'b1;
          end
        end
        default: begin
          ackrx    <= 1'b0;
          rx_state <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_dev_if.sv
// Self-checking bench for sw_dev_if: scripted handshake scenarios plus randomized concurrent traffic against queue models.
module tb_sw_dev_if;
  localparam int DW = 4, AW_DEV = 2, AW = AW_DEV + 1, RW = DW + AW, TO_CYC = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          tx_valid = 1'b0, tx_ready, tx_done, tx_err;
  logic [DW-1:0] tx_data = '0, dat_tx, rx_data;
  logic [AW-1:0] tx_adr = '0, adr_tx, rx_adr;
  logic          validtx, acktx = 1'b0, validrx = 1'b0, ackrx, rx_valid, rx_ready = 1'b0;
  logic [RW-1:0] dat_rx = '0;

  sw_dev_if #(.DW(DW), .AW_DEV(AW_DEV), .TO_CYC(TO_CYC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_adr(tx_adr),
    .tx_done(tx_done), .tx_err(tx_err),
    .validtx(validtx), .dat_tx(dat_tx), .adr_tx(adr_tx), .acktx(acktx),
    .validrx(validrx), .dat_rx(dat_rx), .ackrx(ackrx),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_adr(rx_adr)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0, to_fail = 0;

  // Event counters sampled on the falling edge.
  int done_cnt = 0, err_cnt = 0, rise_cnt = 0, short_cnt = 0, unstable_cnt = 0, done_ready_bad = 0;
  int ack_w = 0;
  logic prev_ack = 1'b0, prev_vt = 1'b0;
  logic [RW-1:0] prev_word = '0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      ack_w   <= 0;
      prev_ack <= 1'b0;
      prev_vt  <= 1'b0;
    end else begin
      if (tx_done) begin
        done_cnt <= done_cnt + 1;
        if (!tx_ready) done_ready_bad <= done_ready_bad + 1;
      end
      if (tx_err) err_cnt <= err_cnt + 1;
      if (ackrx && !prev_ack) rise_cnt <= rise_cnt + 1;
      if (ackrx) ack_w <= ack_w + 1;
      else begin
        if (ack_w == 1) short_cnt <= short_cnt + 1;
        ack_w <= 0;
      end
      if (validtx && prev_vt && ({adr_tx, dat_tx} !== prev_word)) unstable_cnt <= unstable_cnt + 1;
      prev_ack  <= ackrx;
      prev_vt   <= validtx;
      prev_word <= {adr_tx, dat_tx};
    end
  end

  logic [RW-1:0] exp_tx[$], got_tx[$], exp_rx[$], got_rx[$];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_send(input logic [RW-1:0] w, output bit ok);
    int n = 0;
    ok = 1'b1;
    tx_data  = w[DW-1:0];
    tx_adr   = w[RW-1:DW];
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 300) begin step(); n++; end
    if (n >= 300) ok = 1'b0;
    else step();
    tx_valid = 1'b0;
  endtask

  task automatic port_tx(input int al, input int rl, output logic [RW-1:0] w, output bit ok);
    int n = 0;
    ok = 1'b1;
    w  = '0;
    while (validtx !== 1'b1 && n < 300) begin step(); n++; end
    if (n >= 300) begin ok = 1'b0; return; end
    w = {adr_tx, dat_tx};
    repeat (al) step();
    acktx = 1'b1;
    n = 0;
    while (validtx !== 1'b0 && n < 300) begin step(); n++; end
    if (n >= 300) ok = 1'b0;
    repeat (rl) step();
    acktx = 1'b0;
  endtask

  task automatic port_rx(input logic [RW-1:0] w, output bit ok);
    int n = 0;
    ok = 1'b1;
    validrx = 1'b1;
    dat_rx  = w;
    while (ackrx !== 1'b1 && n < 600) begin step(); n++; end
    if (n >= 600) ok = 1'b0;
    validrx = 1'b0;
    dat_rx  = RW'($urandom());
    n = 0;
    while (ackrx !== 1'b0 && n < 50) begin step(); n++; end
    if (n >= 50) ok = 1'b0;
  endtask

  task automatic run_traffic(input int n_tx, input int n_rx, input int lat_max, input int gap_max, input int pct);
    exp_tx.delete(); got_tx.delete(); exp_rx.delete(); got_rx.delete();
    fork
      begin
        for (int i = 0; i < n_tx; i++) begin
          logic [RW-1:0] w;
          bit ok;
          w = RW'($urandom());
          exp_tx.push_back(w);
          host_send(w, ok);
          if (!ok) to_fail++;
          repeat (int'($urandom_range(0, gap_max))) step();
        end
      end
      begin
        for (int i = 0; i < n_tx; i++) begin
          logic [RW-1:0] w;
          bit ok;
          port_tx(int'($urandom_range(0, lat_max)), int'($urandom_range(0, lat_max)), w, ok);
          if (ok) got_tx.push_back(w);
          else to_fail++;
        end
      end
      begin
        for (int i = 0; i < n_rx; i++) begin
          logic [RW-1:0] w;
          bit ok;
          w = RW'($urandom());
          exp_rx.push_back(w);
          port_rx(w, ok);
          if (!ok) to_fail++;
          repeat (int'($urandom_range(0, gap_max))) step();
        end
      end
      begin
        int cyc = 0;
        while (got_rx.size() < n_rx && cyc < 5000) begin
          rx_ready = (int'($urandom_range(0, 99)) < pct);
          if (rx_valid && rx_ready) got_rx.push_back({rx_adr, rx_data});
          step();
          cyc++;
        end
        rx_ready = 1'b0;
        if (cyc >= 5000) to_fail++;
      end
    join
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #11;
    total++;
    if ({tx_ready, validtx, tx_done, tx_err, ackrx, rx_valid} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctl: got %b want 100000", {tx_ready, validtx, tx_done, tx_err, ackrx, rx_valid});
    end
    total++;
    if ({dat_tx, adr_tx, rx_data, rx_adr} !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {dat_tx, adr_tx, rx_data, rx_adr});
    end
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    // Open one handshake on each side, then pull reset between edges.
    tx_data = 4'h6; tx_adr = 3'b010; tx_valid = 1'b1;
    validrx = 1'b1; dat_rx = 7'b1010101; rx_ready = 1'b0;
    step();
    tx_valid = 1'b0;
    total++;
    if ({validtx, ackrx} !== 2'b11) begin
      bad++; $display("FAIL reset_pre: got validtx,ackrx=%b want 11", {validtx, ackrx});
    end
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if ({validtx, ackrx} !== 2'b00) begin
      bad++; $display("FAIL reset_async_drop: got validtx,ackrx=%b want 00", {validtx, ackrx});
    end
    validrx = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    total++;
    if ({tx_ready, validtx, rx_valid} !== 3'b100) begin
      bad++; $display("FAIL reset_release: got tx_ready,validtx,rx_valid=%b want 100", {tx_ready, validtx, rx_valid});
    end
  endtask

  task automatic test_tx_basic();
    int d0 = done_cnt, u0 = unstable_cnt, hold_bad = 0;
    acktx = 1'b0;
    tx_data = 4'hA; tx_adr = 3'b101; tx_valid = 1'b1;
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL txb_idle_ready: got %b want 1", tx_ready); end
    step();
    tx_valid = 1'b0; tx_data = 4'h5; tx_adr = 3'b010;
    total++;
    if ({validtx, tx_ready, adr_tx, dat_tx} !== {1'b1, 1'b0, 3'b101, 4'hA}) begin
      bad++; $display("FAIL txb_request: got v=%b r=%b adr=%0h dat=%0h want v=1 r=0 adr=5 dat=a", validtx, tx_ready, adr_tx, dat_tx);
    end
    repeat (2) begin
      step();
      if ({validtx, tx_ready, tx_done, adr_tx, dat_tx} !== {3'b100, 3'b101, 4'hA}) hold_bad++;
    end
    acktx = 1'b1;
    step();
    if ({validtx, tx_ready, tx_done} !== 3'b000) hold_bad++;
    step();
    if ({validtx, tx_ready, tx_done} !== 3'b000) hold_bad++;
    total++;
    if (hold_bad !== 0) begin bad++; $display("FAIL txb_hold: got %0d bad cycles want 0", hold_bad); end
    acktx = 1'b0;
    step();
    total++;
    if ({tx_done, tx_ready} !== 2'b11) begin
      bad++; $display("FAIL txb_done: got done,ready=%b want 11", {tx_done, tx_ready});
    end
    step();
    total++;
    if (tx_done !== 1'b0 || done_cnt - d0 !== 1 || unstable_cnt !== u0) begin
      bad++; $display("FAIL txb_single: got done=%b pulses=%0d unstable=%0d want 0/1/0", tx_done, done_cnt - d0, unstable_cnt - u0);
    end
  endtask

  task automatic test_rx_basic();
    int r0 = rise_cnt, s0 = short_cnt;
    rx_ready = 1'b0;
    validrx = 1'b1; dat_rx = 7'b0110011;
    step();
    total++;
    if ({ackrx, rx_valid, rx_adr, rx_data} !== {2'b11, 3'b011, 4'h3}) begin
      bad++; $display("FAIL rxb_capture: got ack=%b v=%b adr=%0h dat=%0h want 1/1/3/3", ackrx, rx_valid, rx_adr, rx_data);
    end
    validrx = 1'b0; dat_rx = 7'b1111111;
    step();
    total++;
    if (ackrx !== 1'b1) begin bad++; $display("FAIL rxb_ack_min: got ackrx=%b want 1", ackrx); end
    step();
    total++;
    if ({ackrx, rx_valid} !== 2'b01) begin
      bad++; $display("FAIL rxb_release: got ack,valid=%b want 01", {ackrx, rx_valid});
    end
    repeat (3) step();
    total++;
    if (rise_cnt - r0 !== 1 || short_cnt !== s0 || {rx_adr, rx_data} !== 7'b0110011) begin
      bad++; $display("FAIL rxb_once: got rises=%0d short=%0d word=%h want 1/0/33", rise_cnt - r0, short_cnt - s0, {rx_adr, rx_data});
    end
  endtask

  task automatic test_rx_backpressure();
    logic [RW-1:0] w2;
    int hold_bad = 0;
    do w2 = RW'($urandom()); while (w2 == 7'b0110011);
    validrx = 1'b1; dat_rx = w2;
    repeat (4) begin
      step();
      if (ackrx !== 1'b0 || {rx_adr, rx_data} !== 7'b0110011 || rx_valid !== 1'b1) hold_bad++;
    end
    total++;
    if (hold_bad !== 0) begin bad++; $display("FAIL rxbp_hold: got %0d bad cycles want 0", hold_bad); end
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    total++;
    if ({ackrx, rx_valid} !== 2'b11 || {rx_adr, rx_data} !== w2) begin
      bad++; $display("FAIL rxbp_second: got ack=%b v=%b word=%h want 1/1/%h", ackrx, rx_valid, {rx_adr, rx_data}, w2);
    end
    validrx = 1'b0;
    repeat (2) step();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    total++;
    if ({ackrx, rx_valid} !== 2'b00) begin
      bad++; $display("FAIL rxbp_drain: got ack,valid=%b want 00", {ackrx, rx_valid});
    end
  endtask

`ifdef SW_DEV_IF_TIMEOUT_EN
  task automatic test_timeout();
    int e0 = err_cnt, d0 = done_cnt, hold_bad = 0;
    acktx = 1'b0;
    tx_data = 4'h9; tx_adr = 3'b110; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (15) begin
      if (validtx !== 1'b1) hold_bad++;
      step();
    end
    if (validtx !== 1'b1) hold_bad++;
    total++;
    if (hold_bad !== 0) begin bad++; $display("FAIL to_hold: got %0d low cycles want 0", hold_bad); end
    step();
    total++;
    if ({validtx, tx_err, tx_ready} !== 3'b011) begin
      bad++; $display("FAIL to_fire: got v,err,ready=%b want 011", {validtx, tx_err, tx_ready});
    end
    step();
    total++;
    if (tx_err !== 1'b0 || err_cnt - e0 !== 1 || done_cnt !== d0) begin
      bad++; $display("FAIL to_pulse: got err=%b errs=%0d dones=%0d want 0/1/0", tx_err, err_cnt - e0, done_cnt - d0);
    end
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (15) step();
    acktx = 1'b1;
    step();
    total++;
    if ({validtx, tx_err} !== 2'b00) begin
      bad++; $display("FAIL to_ack_wins: got v,err=%b want 00", {validtx, tx_err});
    end
    acktx = 1'b0;
    step();
    total++;
    if (tx_done !== 1'b1) begin bad++; $display("FAIL to_ack_done: got %b want 1", tx_done); end
    step();
    total++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 1) begin
      bad++; $display("FAIL to_counts: got errs=%0d dones=%0d want 1/1", err_cnt - e0, done_cnt - d0);
    end
  endtask
`else
  task automatic test_no_timeout();
    int e0 = err_cnt, d0 = done_cnt, hold_bad = 0;
    acktx = 1'b0;
    tx_data = 4'h9; tx_adr = 3'b110; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (40) begin
      if (validtx !== 1'b1 || tx_err !== 1'b0) hold_bad++;
      step();
    end
    total++;
    if (hold_bad !== 0) begin bad++; $display("FAIL nto_hold: got %0d bad cycles want 0", hold_bad); end
    acktx = 1'b1;
    step();
    acktx = 1'b0;
    step();
    total++;
    if (tx_done !== 1'b1) begin bad++; $display("FAIL nto_done: got %b want 1", tx_done); end
    step();
    total++;
    if (err_cnt !== e0 || done_cnt - d0 !== 1) begin
      bad++; $display("FAIL nto_counts: got errs=%0d dones=%0d want 0/1", err_cnt - e0, done_cnt - d0);
    end
  endtask
`endif

  task automatic check_traffic(input string tag, input int n_tx, input int n_rx,
                               input int d0, input int r0, input int e0, input int f0);
    int mism = 0;
    total++;
    if (to_fail !== f0) begin bad++; $display("FAIL %s_bounds: got %0d expired waits want 0", tag, to_fail - f0); end
    total++;
    if (got_tx.size() !== n_tx || got_rx.size() !== n_rx) begin
      bad++; $display("FAIL %s_sizes: got tx=%0d rx=%0d want %0d/%0d", tag, got_tx.size(), got_rx.size(), n_tx, n_rx);
    end
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++) if (got_tx[i] !== exp_tx[i]) mism++;
    for (int i = 0; i < got_rx.size() && i < exp_rx.size(); i++) if (got_rx[i] !== exp_rx[i]) mism++;
    total++;
    if (mism !== 0) begin bad++; $display("FAIL %s_data: got %0d mismatched words want 0", tag, mism); end
    total++;
    if (done_cnt - d0 !== n_tx || rise_cnt - r0 !== n_rx || err_cnt !== e0) begin
      bad++; $display("FAIL %s_events: got dones=%0d acks=%0d errs=%0d want %0d/%0d/0", tag,
                      done_cnt - d0, rise_cnt - r0, err_cnt - e0, n_tx, n_rx);
    end
    total++;
    if (short_cnt !== 0 || unstable_cnt !== 0 || done_ready_bad !== 0) begin
      bad++; $display("FAIL %s_protocol: got short=%0d unstable=%0d ready_at_done_bad=%0d want 0/0/0", tag,
                      short_cnt, unstable_cnt, done_ready_bad);
    end
  endtask

  task automatic test_concurrent();
    int d0 = done_cnt, r0 = rise_cnt, e0 = err_cnt, f0 = to_fail;
    run_traffic(30, 30, 4, 3, 60);
    repeat (3) step();
    check_traffic("conc", 30, 30, d0, r0, e0, f0);
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, r0 = rise_cnt, e0 = err_cnt, f0 = to_fail;
    run_traffic(10, 10, 0, 0, 100);
    repeat (3) step();
    check_traffic("b2b", 10, 10, d0, r0, e0, f0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_basic();
    test_rx_basic();
    test_rx_backpressure();
`ifdef SW_DEV_IF_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_concurrent();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_dev_if.md
Name: sw_dev_if

Overview:
- Device-side endpoint of the switch port's 4-phase handshakes.
- Host/device logic sees simple valid/ready streams.
- Initiator of the TX handshake: drives validtx, data and address, waits for acktx.
- Responder of the RX handshake: consumes validrx, pulses the port FIFO read via ackrx, buffers one word for the host.
- One instance sits between each attached device and its switch port.

Parameters:
- DW, 4, payload data width.
- AW_DEV, 2, device address bits; full address is AW_DEV+1 bits (MSB = switch select).
- TO_CYC, 16, TX ack timeout in cycles; used only with the optional feature; minimum 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- tx_valid  in  1  host has a word to send.
- tx_ready  out  1  block can accept a host word.
- tx_data  in  DW  host payload.
- tx_adr  in  AW_DEV+1  destination address.
- tx_done  out  1  one-cycle pulse: handshake completed.
- tx_err  out  1  one-cycle pulse: handshake timed out.
- validtx  out  1  to port: valid request.
- dat_tx  out  DW  to port: data.
- adr_tx  out  AW_DEV+1  to port: address.
- acktx  in  1  from port: acknowledge.
- validrx  in  1  from port: word available.
- dat_rx  in  DW+AW_DEV+1  from port FIFO output; [DW-1:0] data, upper bits address tag.
- ackrx  out  1  to port: word taken.
- rx_valid  out  1  host output word valid.
- rx_ready  in  1  host accepts word.
- rx_data  out  DW  received data.
- rx_adr  out  AW_DEV+1  received address tag.

Behaviour:
- Reset: async on rst_ni low, released synchronously to clk_i.
- Reset values: tx_ready=1; validtx=0; dat_tx=0; adr_tx=0; tx_done=0; tx_err=0; ackrx=0; rx_valid=0; rx_data=0; rx_adr=0. TX FSM in T_IDLE, RX FSM in R_IDLE.
- Reset mid-handshake: abandons the transfer. validtx or ackrx drops immediately (asynchronous).

TX FSM (T_IDLE, T_REQ, T_REL):
- T_IDLE: tx_ready=1. On tx_valid&tx_ready, latch tx_data/tx_adr into dat_tx/adr_tx, set validtx=1 on the next edge, go to T_REQ. No host word is accepted in the same cycle as the return to T_IDLE.
- T_REQ: validtx held; dat_tx/adr_tx stable; tx_ready=0. On acktx=1, validtx<=0, go to T_REL.
- T_REL: wait for acktx=0. Then pulse tx_done for one cycle and go to T_IDLE. tx_ready rises in the same cycle as tx_done.
- Minimum turn: accept to tx_done = 3 cycles plus port latency. Back-to-back words are separated by at least one idle cycle of validtx.
- acktx=1 seen in T_IDLE is ignored. No request is issued until acktx=0.

RX FSM (R_IDLE, R_ACK):
- R_IDLE: when validrx=1 and (rx_valid=0 or rx_ready=1), capture dat_rx into rx_data/rx_adr, set rx_valid=1, set ackrx=1, go to R_ACK. Capture happens exactly once per handshake.
- R_ACK: hold ackrx=1 until validrx=0, then ackrx<=0, go to R_IDLE.
- The port's edge detector needs ackrx high for at least 2 cycles. The FSM guarantees this by holding ackrx for a minimum of 2 cycles regardless of validrx.
- Host side: rx_valid clears on rx_valid&rx_ready unless a new capture occurs in the same cycle (capture wins, rx_valid stays 1).
- Backpressure: while rx_valid=1 and rx_ready=0, ackrx stays 0 and the port keeps the word.
- TX and RX FSMs are independent. Simultaneous activity on both is legal.

Optional Feature:
- SW_DEV_IF_TIMEOUT_EN defined:
  - A counter of width ceil(log2(TO_CYC+1)) clears on entry to T_REQ and increments each T_REQ cycle with acktx=0.
  - At count==TO_CYC-1 with acktx still 0: validtx<=0, pulse tx_err, go to T_IDLE. The word is dropped and tx_done does not pulse.
  - acktx arriving in the same cycle as the timeout: ack wins, normal T_REL path.
- SW_DEV_IF_TIMEOUT_EN undefined: no counter; T_REQ waits indefinitely; tx_err tied to 0.

Test Plan:
- Reset: rst_ni=0 mid-T_REQ with validtx=1 -> validtx=0 immediately; tx_ready=1 after release.
- TX basic: tx_data=4'hA, tx_adr=3'b101, port acks 2 cycles after validtx and drops ack 1 cycle after validtx falls -> dat_tx=A and adr_tx=5 stable throughout; single tx_done pulse; tx_ready=0 until tx_done.
- RX basic: validrx=1 with dat_rx=7'b0110011 -> ackrx high for ≥2 cycles; rx_data=4'h3; rx_adr=3'b011; rx_valid=1; exactly one capture.
- RX backpressure: rx_ready=0 with a second validrx pending -> ackrx stays 0 and the first word is held. Raising rx_ready for 1 cycle -> second word is captured the same cycle; rx_valid stays 1.
- Concurrent: a TX handshake and an RX handshake overlapping in time -> both complete, one tx_done pulse, one capture, no interference.
- Timeout (SW_DEV_IF_TIMEOUT_EN, TO_CYC=16): acktx held at 0 -> validtx falls after 16 cycles of T_REQ; tx_err pulses once; no tx_done. Repeating with acktx rising at cycle 16 -> normal completion, tx_err=0.
